// File: rtl/secded_pkg.sv
// Shared types, bit positions and encode function for the SEC-DED encoder engine.
// SECDED_ENC_VERIFY_EN adds the read-back verify states to the state enum.
package secded_pkg;

    // Codeword bit positions of the parity bits, shared with the decoder model.
    localparam int unsigned P0 = 0;
    localparam int unsigned P1 = 1;
    localparam int unsigned P2 = 2;
    localparam int unsigned P4 = 4;
    localparam int unsigned P8 = 8;

    typedef logic [15:0] codeword_t;
    typedef logic [11:1] msg_t;

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StWrLo,
        StWrHi,
`ifdef SECDED_ENC_VERIFY_EN
        StFin,
        StVfLo,
        StVfHi
`else
        StFin
`endif
    } state_t;

    function automatic codeword_t secded_encode(input msg_t d);
        codeword_t cw;
        cw        = '0;
        cw[15:9]  = d[11:5];
        cw[P8]    = ^d[11:5];
        cw[7:5]   = d[4:2];
        cw[P4]    = (^d[11:8]) ^ (^d[4:2]);
        cw[3]     = d[1];
        cw[P2]    = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        cw[P1]    = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        cw[P0]    = ^cw[15:1];
        return cw;
    endfunction

endpackage

// File: rtl/secded_enc_engine_if.sv
// Control handshake and data-memory port of the SEC-DED encoder engine.
// SECDED_ENC_VERIFY_EN adds the sticky vfy_err status signal.
interface secded_enc_engine_if #(
    parameter int ADDR_W = 8
);
    logic              init;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;
`ifdef SECDED_ENC_VERIFY_EN
    logic              vfy_err;

    // The engine masters the memory port.
    modport master (input init, input mem_rd_data, output done, output mem_addr,
                    output mem_wr_en, output mem_wr_data, output vfy_err);
    modport slave (output init, output mem_rd_data, input done, input mem_addr,
                   input mem_wr_en, input mem_wr_data, input vfy_err);
`else
    modport master (input init, input mem_rd_data, output done, output mem_addr,
                    output mem_wr_en, output mem_wr_data);
    modport slave (output init, output mem_rd_data, input done, input mem_addr,
                   input mem_wr_en, input mem_wr_data);
`endif
endinterface

// File: rtl/secded_enc_comb.sv
// Purely combinational 11-bit message to 16-bit SEC-DED codeword encoder.
module secded_enc_comb
    import secded_pkg::*;
(
    input  msg_t      msg,
    output codeword_t cw
);
    assign cw = secded_encode(msg);
endmodule

// File: rtl/secded_enc_engine.sv
// SEC-DED encoder engine: reads NUM_MSG messages, writes codewords back to memory.
// SECDED_ENC_VERIFY_EN adds read-back verify states and the vfy_err output.
module secded_enc_engine
    import secded_pkg::*;
#(
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int NUM_MSG  = 15,
    parameter int ADDR_W   = 8
) (
    input logic                 clk,
    input logic                 reset,
    secded_enc_engine_if.master bus
);

    localparam int IdxW = (NUM_MSG > 0) ? $clog2(NUM_MSG + 1) : 1;
    typedef logic [IdxW-1:0] idx_t;

    state_t            state_q, state_d;
    idx_t              idx_q, idx_d;
    msg_t              msg_q, msg_d;
    logic              done_q, done_d;
    codeword_t         cw;
    logic              step_done;
    logic              last_msg;
    logic [ADDR_W-1:0] idx_off, src_addr, dst_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;
`ifdef SECDED_ENC_VERIFY_EN
    logic              vfy_err_q, vfy_err_d;
`endif

    secded_enc_comb u_enc (
        .msg (msg_q),
        .cw  (cw)
    );

    // Byte addresses wrap modulo 2^ADDR_W.
    assign idx_off  = ADDR_W'({idx_q, 1'b0});
    assign src_addr = ADDR_W'(SRC_BASE) + idx_off;
    assign dst_addr = ADDR_W'(DST_BASE) + idx_off;
    assign last_msg = (int'(idx_q) == NUM_MSG - 1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        msg_d       = msg_q;
        done_d      = done_q;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        step_done   = 1'b0;
`ifdef SECDED_ENC_VERIFY_EN
        vfy_err_d   = vfy_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.init) begin
                    done_d  = 1'b0;
                    idx_d   = '0;
`ifdef SECDED_ENC_VERIFY_EN
                    vfy_err_d = 1'b0;
`endif
                    state_d = (NUM_MSG == 0) ? StFin : StRdLo;
                end
            end
            StRdLo: begin
                mem_addr   = src_addr;
                msg_d[8:1] = bus.mem_rd_data;
                state_d    = StRdHi;
            end
            StRdHi: begin
                mem_addr    = src_addr + ADDR_W'(1);
                msg_d[11:9] = bus.mem_rd_data[2:0];
                state_d     = StWrLo;
            end
            StWrLo: begin
                mem_addr    = dst_addr;
                mem_wr_en   = 1'b1;
                mem_wr_data = cw[7:0];
                state_d     = StWrHi;
            end
            StWrHi: begin
                mem_addr    = dst_addr + ADDR_W'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = cw[15:8];
`ifdef SECDED_ENC_VERIFY_EN
                state_d     = StVfLo;
            end
            StVfLo: begin
                mem_addr = dst_addr;
                if (bus.mem_rd_data != cw[7:0]) vfy_err_d = 1'b1;
                state_d  = StVfHi;
            end
            StVfHi: begin
                mem_addr  = dst_addr + ADDR_W'(1);
                if (bus.mem_rd_data != cw[15:8]) vfy_err_d = 1'b1;
                step_done = 1'b1;
`else
                step_done   = 1'b1;
`endif
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Final state of a message: finish the run or move to the next message.
        if (step_done) begin
            if (last_msg) begin
                state_d = StFin;
            end else begin
                idx_d   = idx_q + idx_t'(1);
                state_d = StRdLo;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            msg_q     <= '0;
            done_q    <= 1'b0;
`ifdef SECDED_ENC_VERIFY_EN
            vfy_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            msg_q     <= msg_d;
            done_q    <= done_d;
`ifdef SECDED_ENC_VERIFY_EN
            vfy_err_q <= vfy_err_d;
`endif
        end
    end

    assign bus.done        = done_q;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wr_en   = mem_wr_en;
    assign bus.mem_wr_data = mem_wr_data;
`ifdef SECDED_ENC_VERIFY_EN
    assign bus.vfy_err     = vfy_err_q;
`endif

endmodule

// File: tb/tb_secded_enc_engine.sv
// Self-checking bench for secded_enc_engine: vector table, write scoreboard, abort/idle cases.
module tb_secded_enc_engine;

`ifdef SECDED_ENC_VERIFY_EN
    localparam int CycPerMsg = 6;
`else
    localparam int CycPerMsg = 4;
`endif

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] cw;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    secded_enc_engine_if #(.ADDR_W(8)) bus15 ();
    secded_enc_engine_if #(.ADDR_W(8)) bus1 ();
    secded_enc_engine_if #(.ADDR_W(8)) bus0 ();

    secded_enc_engine #(.SRC_BASE(0), .DST_BASE(30), .NUM_MSG(15), .ADDR_W(8)) dut15 (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus15)
    );
    secded_enc_engine #(.SRC_BASE(0), .DST_BASE(30), .NUM_MSG(1), .ADDR_W(8)) dut1 (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus1)
    );
    secded_enc_engine #(.SRC_BASE(0), .DST_BASE(30), .NUM_MSG(0), .ADDR_W(8)) dut0 (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus0)
    );

    logic [7:0] mem15 [256];
    logic [7:0] mem1  [256];
    logic       ld15, ld1;
    logic [7:0] ld_addr, ld_data;

    assign bus15.mem_rd_data = mem15[bus15.mem_addr];
    assign bus1.mem_rd_data  = mem1[bus1.mem_addr];
    assign bus0.mem_rd_data  = 8'h00;

    always @(posedge clk) begin
        if (ld15) mem15[ld_addr] <= ld_data;
        else if (bus15.mem_wr_en) mem15[bus15.mem_addr] <= bus15.mem_wr_data;
        if (ld1) mem1[ld_addr] <= ld_data;
        else if (bus1.mem_wr_en) mem1[bus1.mem_addr] <= bus1.mem_wr_data;
    end

    int   n_checks = 0;
    int   n_err    = 0;
    int   w0       = 0;
    wr_t  q15[$];
    wr_t  q1[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Reference encoder written in Hamming-position form.
    function automatic logic [15:0] tb_encode(input logic [10:0] m);
        logic [15:0] c;
        logic        p;
        int          di;
        c  = '0;
        di = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = m[di];
                di++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int pos = 1; pos < 16; pos++) if (pos[k] && ((pos & (pos - 1)) != 0)) p ^= c[pos];
            c[1 << k] = p;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] tb_decode(input logic [15:0] cw_in);
        logic [15:0] c;
        logic [10:0] m;
        int          s;
        int          di;
        c = cw_in;
        s = 0;
        for (int pos = 1; pos < 16; pos++) if (c[pos]) s ^= pos;
        if (s != 0) c[s] = ~c[s];
        di = 0;
        m  = '0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                m[di] = c[pos];
                di++;
            end
        end
        return m;
    endfunction

    // Write scoreboards, sampled on the falling edge before the write lands.
    always @(negedge clk) begin
        wr_t e;
        if (bus15.mem_wr_en === 1'b1) begin
            if (q15.size() == 0) begin
                chk("unexpected write dut15", 32'({bus15.mem_addr, bus15.mem_wr_data}), 32'hFFFFFFFF);
            end else begin
                e = q15.pop_front();
                chk("write dut15", 32'({bus15.mem_addr, bus15.mem_wr_data}), 32'(e));
            end
        end
        if (bus1.mem_wr_en === 1'b1) begin
            if (q1.size() == 0) begin
                chk("unexpected write dut1", 32'({bus1.mem_addr, bus1.mem_wr_data}), 32'hFFFFFFFF);
            end else begin
                e = q1.pop_front();
                chk("write dut1", 32'({bus1.mem_addr, bus1.mem_wr_data}), 32'(e));
            end
        end
        if (bus0.mem_wr_en !== 1'b0) w0++;
    end

    task automatic load(input int which, input int addr, input logic [7:0] data);
        @(negedge clk);
        ld_addr = addr[7:0];
        ld_data = data;
        if (which == 15) ld15 = 1'b1;
        else ld1 = 1'b1;
        @(negedge clk);
        ld15 = 1'b0;
        ld1  = 1'b0;
    endtask

    task automatic set_init(input int which, input logic v);
        case (which)
            15:      bus15.init = v;
            1:       bus1.init  = v;
            default: bus0.init  = v;
        endcase
    endtask

    function automatic logic get_done(input int which);
        case (which)
            15:      return bus15.done;
            1:       return bus1.done;
            default: return bus0.done;
        endcase
    endfunction

    task automatic push_cw(input int which, input int i, input logic [15:0] cw);
        wr_t lo, hi;
        lo.addr = 8'(30 + 2 * i);
        lo.data = cw[7:0];
        hi.addr = 8'(31 + 2 * i);
        hi.data = cw[15:8];
        if (which == 15) begin
            q15.push_back(lo);
            q15.push_back(hi);
        end else begin
            q1.push_back(lo);
            q1.push_back(hi);
        end
    endtask

    task automatic run(input int which, input int exp_edges, input bit poke_busy,
                       input string name);
        int n;
        bit seen;
        @(negedge clk);
        set_init(which, 1'b1);
        @(posedge clk);
        #1;
        set_init(which, 1'b0);
        chk({name, " done cleared"}, 32'(get_done(which)), 32'd0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (poke_busy && n == 10) set_init(which, 1'b1);
            if (poke_busy && n == 11) set_init(which, 1'b0);
            if (get_done(which) === 1'b1) seen = 1'b1;
        end
        chk({name, " latency"}, 32'(n), 32'(exp_edges));
        repeat (3) @(posedge clk);
        #1;
        chk({name, " done held"}, 32'(get_done(which)), 32'd1);
    endtask

    vec_t        vt[6];
    logic [10:0] msgs[15];
    logic [15:0] cw;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{lo: 8'h00, hi: 8'h00, cw: 16'h0000};
        vt[1] = '{lo: 8'hFF, hi: 8'h07, cw: 16'hFFFF};
        vt[2] = '{lo: 8'h01, hi: 8'h00, cw: 16'h000F};
        vt[3] = '{lo: 8'h00, hi: 8'h04, cw: 16'h8117};
        vt[4] = '{lo: 8'h01, hi: 8'hF8, cw: 16'h000F};
        vt[5] = '{lo: 8'h00, hi: 8'hFC, cw: 16'h8117};

        rst_a      = 1'b0;
        rst_b      = 1'b0;
        bus15.init = 1'b0;
        bus1.init  = 1'b0;
        bus0.init  = 1'b0;
        ld15       = 1'b0;
        ld1        = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        repeat (2) @(negedge clk);
        chk("reset done", 32'(bus15.done), 32'd0);
        chk("reset wr_en", 32'(bus15.mem_wr_en), 32'd0);
        chk("reset addr", 32'(bus15.mem_addr), 32'd0);
        chk("reset wr_data", 32'(bus15.mem_wr_data), 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Single-message vectors.
        foreach (vt[i]) begin
            load(1, 0, vt[i].lo);
            load(1, 1, vt[i].hi);
            push_cw(1, 0, vt[i].cw);
            run(1, CycPerMsg + 1, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d lo byte", i), 32'(mem1[30]), 32'(vt[i].cw[7:0]));
            chk($sformatf("vec%0d hi byte", i), 32'(mem1[31]), 32'(vt[i].cw[15:8]));
        end
        chk("dut1 queue drained", 32'(q1.size()), 32'd0);
`ifdef SECDED_ENC_VERIFY_EN
        chk("dut1 vfy_err", 32'(bus1.vfy_err), 32'd0);
`endif

        // NUM_MSG=0: done one edge after init, no writes.
        run(0, 1, 1'b0, "zero");
        chk("zero writes", 32'(w0), 32'd0);

        // Fifteen random messages with garbage in the upper source bits.
        foreach (msgs[i]) begin
            msgs[i] = 11'($urandom_range(0, 2047));
            load(15, 2 * i, msgs[i][7:0]);
            load(15, 2 * i + 1, {5'($urandom), msgs[i][10:8]});
            push_cw(15, i, tb_encode(msgs[i]));
        end
        run(15, 15 * CycPerMsg + 1, 1'b1, "rand");
        chk("rand queue drained", 32'(q15.size()), 32'd0);
        foreach (msgs[i]) begin
            cw = {mem15[31 + 2 * i], mem15[30 + 2 * i]};
            cw[$urandom_range(0, 15)] ^= 1'b1;
            chk($sformatf("decode msg%0d", i), 32'(tb_decode(cw)), 32'(msgs[i]));
        end

        // Reset during WR_LO of message 3.
        load(15, 36, 8'hAA);
        load(15, 37, 8'hAA);
        foreach (msgs[i]) push_cw(15, i, tb_encode(msgs[i]));
        @(negedge clk);
        bus15.init = 1'b1;
        @(posedge clk);
        #1;
        bus15.init = 1'b0;
        begin
            int n;
            n = 0;
            while (!(bus15.mem_wr_en === 1'b1 && bus15.mem_addr == 8'd36) && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("abort reached msg3", 32'(n < 200), 32'd1);
        end
        rst_a = 1'b0;
        #1;
        chk("abort wr_en", 32'(bus15.mem_wr_en), 32'd0);
        chk("abort done", 32'(bus15.done), 32'd0);
        chk("abort writes left", 32'(q15.size()), 32'd24);
        q15.delete();
        repeat (5) @(negedge clk);
        chk("abort byte 36", 32'(mem15[36]), 32'h000000AA);
        chk("abort byte 37", 32'(mem15[37]), 32'h000000AA);
        rst_a = 1'b1;
        @(negedge clk);
        chk("post-abort done", 32'(bus15.done), 32'd0);

        foreach (msgs[i]) push_cw(15, i, tb_encode(msgs[i]));
        run(15, 15 * CycPerMsg + 1, 1'b0, "rerun");
        chk("rerun queue drained", 32'(q15.size()), 32'd0);
        cw = tb_encode(msgs[3]);
        chk("rerun byte 36", 32'(mem15[36]), 32'(cw[7:0]));
        chk("rerun byte 37", 32'(mem15[37]), 32'(cw[15:8]));
`ifdef SECDED_ENC_VERIFY_EN
        chk("dut15 vfy_err", 32'(bus15.vfy_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
